// File: rtl/vga_pkg.sv
// Shared raster timing constants and coordinate type used by the timing
// generator and the comparator/renderer side.
package vga_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int unsigned DEF_CLK_DIV   = 2;
    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    localparam int unsigned DEF_H_TOTAL =
        DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned DEF_V_TOTAL =
        DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int unsigned DEF_HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
    localparam int unsigned DEF_VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

    // Half-open window test [lo, hi) on a coordinate.
    function automatic logic in_window(coord_t c, int unsigned lo, int unsigned hi);
        return (32'(c) >= lo) && (32'(c) < hi);
    endfunction

endpackage

// File: rtl/vga_mod_counter.sv
// Enabled modulo-N coordinate counter; wrap flags the enabled terminal count.
module vga_mod_counter
    import vga_pkg::*;
#(
    parameter int unsigned MODULUS = 800
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output coord_t count,
    output logic   wrap
);

    localparam coord_t LAST = coord_t'(MODULUS - 1);

    assign wrap = en && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + coord_t'(1);
        end
    end

endmodule

// File: rtl/vga_coord_gen.sv
// Raster timing generator: pixel-rate divider, h/v coordinate sweep and
// sync/blanking outputs aligned with the coordinates.
module vga_coord_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK
) (
    input  logic   clk,
    input  logic   rst,
    output coord_t pixel_x,
    output coord_t pixel_y,
    output logic   video_on,
    output logic   hsync,
    output logic   vsync,
    output logic   pixel_tick,
    output logic   frame_tick
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_coord_gen: H_TOTAL/V_TOTAL exceed 10-bit coordinate range");
        end
        if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
            $error("vga_coord_gen: CLK_DIV must be 1..16");
        end
    endgenerate

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0] div;
    logic       h_wrap;
    logic       v_wrap;
    coord_t     x_next;
    coord_t     y_next;

    // With CLK_DIV=1 div stays at 0 and pixel_tick is permanently high.
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + 4'd1;
        end
    end

    assign pixel_tick = (div == DIV_LAST);

    vga_mod_counter #(.MODULUS(H_TOTAL)) u_h_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (pixel_tick),
        .count (pixel_x),
        .wrap  (h_wrap)
    );

    vga_mod_counter #(.MODULUS(V_TOTAL)) u_v_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (h_wrap),
        .count (pixel_y),
        .wrap  (v_wrap)
    );

    assign frame_tick = v_wrap;

    // Syncs are decoded from the coordinates the counters are about to load,
    // so they switch on the same edge as pixel_x/pixel_y.
    always_comb begin
        x_next = pixel_x;
        y_next = pixel_y;
        if (h_wrap) begin
            x_next = '0;
        end else if (pixel_tick) begin
            x_next = pixel_x + coord_t'(1);
        end
        if (v_wrap) begin
            y_next = '0;
        end else if (h_wrap) begin
            y_next = pixel_y + coord_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b1;
        end else begin
            hsync    <= !in_window(x_next, HS_START, HS_END);
            vsync    <= !in_window(y_next, VS_START, VS_END);
            video_on <= (32'(x_next) < H_VISIBLE) && (32'(y_next) < V_VISIBLE);
        end
    end

endmodule
